// File: rtl/ray_aabb_err_monitor.sv
// Accuracy monitor: delays the golden hit/miss by the DUT pipeline latency and keeps
// saturating per-lane Type1 (golden hit, DUT miss) / Type2 (golden miss, DUT hit) counts.
module ray_aabb_err_monitor #(
  parameter int LANES     = 1,
  parameter int LATENCY   = 36,
  parameter int CNT_W     = 16,
  parameter int NUM_TESTS = 10000,
  parameter int IDX_W     = $clog2(NUM_TESTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [LANES-1:0]   gold_in,
  input  logic [LANES-1:0]   dut_hit,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   type1_cnt,
  output logic [CNT_W-1:0]   type2_cnt,
  output logic [CNT_W-1:0]   checked_cnt,
  output logic               err_flag,
  output logic [IDX_W-1:0]   first_err_idx
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX   = (SUM_W'(1) << CNT_W) - SUM_W'(1);
  localparam logic [SUM_W-1:0] LANES_INC = SUM_W'(LANES);
  localparam logic [IDX_W:0]   ISSUE_MAX = (IDX_W + 1)'(NUM_TESTS);
  localparam logic [IDX_W:0]   ONE       = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W:0]   issued;
  logic [IDX_W:0]   retired;
  logic [IDX_W:0]   retired_nxt;
  logic             dl_vld  [LATENCY];
  logic [LANES-1:0] dl_gold [LATENCY];
  logic [IDX_W-1:0] dl_idx  [LATENCY];

  logic             accept;
  logic             cmp;
  logic             start_run;
  logic [LANES-1:0] tail_gold;
  logic [LANES-1:0] mis;
  logic [SUM_W-1:0] t1_inc;
  logic [SUM_W-1:0] t2_inc;

  function automatic logic [SUM_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + SUM_W'(v[i]);
    end
    return n;
  endfunction

  // Widened add then clamp, so a multi-lane step near the top cannot wrap.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + inc;
    return (s > CNT_MAX) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign accept      = (state == S_RUN) && in_valid && (issued < ISSUE_MAX);
  assign cmp         = dl_vld[LATENCY-1] && ((state == S_RUN) || (state == S_DRAIN));
  assign start_run   = start && ((state == S_IDLE) || (state == S_DONE));
  assign tail_gold   = dl_gold[LATENCY-1];
  assign mis         = tail_gold ^ dut_hit;
  assign t1_inc      = popcount(tail_gold & ~dut_hit);
  assign t2_inc      = popcount(~tail_gold & dut_hit);
  assign retired_nxt = retired + (IDX_W + 1)'(cmp);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && ((issued + ONE) == ISSUE_MAX)) state_nxt = S_DRAIN;
      S_DRAIN: if (retired_nxt == issued) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done  <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      issued        <= '0;
      retired       <= '0;
      type1_cnt     <= '0;
      type2_cnt     <= '0;
      checked_cnt   <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_vld[i]  <= 1'b0;
        dl_gold[i] <= '0;
        dl_idx[i]  <= '0;
      end
    end else begin
      dl_vld[0]  <= accept;
      dl_gold[0] <= gold_in;
      dl_idx[0]  <= issued[IDX_W-1:0];
      for (int i = 1; i < LATENCY; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_gold[i] <= dl_gold[i-1];
        dl_idx[i]  <= dl_idx[i-1];
      end
      if (accept) begin
        issued <= issued + ONE;
      end
      if (cmp) begin
        retired     <= retired_nxt;
        type1_cnt   <= sat_add(type1_cnt, t1_inc);
        type2_cnt   <= sat_add(type2_cnt, t2_inc);
        checked_cnt <= sat_add(checked_cnt, LANES_INC);
        if ((|mis) && !err_flag) begin
          err_flag      <= 1'b1;
          first_err_idx <= dl_idx[LATENCY-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_ray_aabb_err_monitor.sv
// Bench for ray_aabb_err_monitor: directed table runs, corner sequences and random
// stimulus, all checked against a queue-based model of the monitor's rules.
module tb_ray_aabb_err_monitor;

  localparam int LANES = 2;
  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int NT    = 8;
  localparam int CMAX  = 15;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [1:0] gold_in, dut_hit;
  logic       busy, done, err_flag;
  logic [3:0] type1_cnt, type2_cnt, checked_cnt;
  logic [2:0] first_err_idx;

  ray_aabb_err_monitor #(
    .LANES(LANES), .LATENCY(LAT), .CNT_W(CW), .NUM_TESTS(NT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .gold_in(gold_in), .dut_hit(dut_hit), .busy(busy), .done(done),
    .type1_cnt(type1_cnt), .type2_cnt(type2_cnt), .checked_cnt(checked_cnt),
    .err_flag(err_flag), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [1:0] sched [128];

  // Reference model: run mode plus a queue of in-flight slots with their due edge.
  typedef struct { int due; logic [1:0] g; int idx; } pend_t;
  pend_t pend[$];
  int m_mode;  // 0 idle, 1 run, 2 drain, 3 done
  int m_issued, m_retired, m_t1, m_t2, m_chk, m_first;
  bit m_err;

  typedef struct {
    logic [15:0] gold;
    logic [15:0] dutv;
    logic [7:0]  vpat;
    int t1, t2, chk;
    bit err;
    int first;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_clear();
    m_issued = 0; m_retired = 0; m_t1 = 0; m_t2 = 0; m_chk = 0; m_first = 0; m_err = 0;
    pend.delete();
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v,
                            input logic [1:0] g, input logic [1:0] d);
    int om;
    pend_t p;
    om = m_mode;
    if (r) begin
      model_clear(); m_mode = 0;
    end else if ((om == 0 || om == 3) && s) begin
      model_clear(); m_mode = 1;
    end else begin
      if ((om == 1 || om == 2) && pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        m_retired++;
        m_t1  = sat(m_t1 + $countones(p.g & ~d));
        m_t2  = sat(m_t2 + $countones(~p.g & d));
        m_chk = sat(m_chk + LANES);
        if (p.g != d && !m_err) begin m_err = 1; m_first = p.idx; end
      end
      if (om == 1 && v && m_issued < NT) begin
        p.due = cyc + LAT; p.g = g; p.idx = m_issued;
        pend.push_back(p);
        m_issued++;
        if (m_issued == NT) m_mode = 2;
      end
      if (om == 2 && m_retired == m_issued) m_mode = 3;
    end
  endtask

  task automatic check_model();
    check("busy", busy, (m_mode == 1 || m_mode == 2));
    check("done", done, (m_mode == 3));
    check("type1_cnt", type1_cnt, m_t1);
    check("type2_cnt", type2_cnt, m_t2);
    check("checked_cnt", checked_cnt, m_chk);
    check("err_flag", err_flag, m_err);
    check("first_err_idx", first_err_idx, m_first);
  endtask

  // One clock edge: drive inputs, let the emulated pipeline answer LAT edges later.
  task automatic tick(input bit r, input bit s, input bit v,
                      input logic [1:0] g, input logic [1:0] resp);
    rst = r; start = s; in_valid = v; gold_in = g;
    dut_hit = sched[cyc % 128];
    sched[cyc % 128] = 2'b00;
    if (v) sched[(cyc + LAT) % 128] = resp;
    model_edge(r, s, v, g, dut_hit);
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  // Issues the 8 slots of one run (after start), then drains with stray in_valid.
  task automatic run_vec(input logic [15:0] gv, input logic [15:0] dv, input logic [7:0] vp);
    int s;
    int c;
    s = 0;
    c = 0;
    while (s < NT && c < 64) begin
      if (vp[c % 8]) begin
        tick(0, (c == 2), 1, gv[2*s +: 2], dv[2*s +: 2]);
        s++;
      end else begin
        tick(0, (c == 2), 0, 2'($urandom), 2'b00);
      end
      c++;
    end
    check("issue_loop_bound", s, NT);
    for (int i = 1; i <= LAT; i++) begin
      tick(0, 0, 1, 2'b11, 2'b00);
      check("done_timing", done, (i == LAT));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) sched[i] = 2'b00;
    m_mode = 0;
    model_clear();
    rst = 1; start = 0; in_valid = 0; gold_in = 0; dut_hit = 0;

    tbl[0] = '{16'hAAAA, 16'hAAAA, 8'hFF, 0,  0, 15, 0, 0};
    tbl[1] = '{16'hA2EA, 16'hAA6A, 8'hFF, 1,  1, 15, 1, 3};
    tbl[2] = '{16'hFFFF, 16'h0000, 8'hFF, 15, 0, 15, 1, 0};
    tbl[3] = '{16'h5555, 16'hFFFF, 8'h6D, 0,  8, 15, 1, 0};
    tbl[4] = '{16'h5555, 16'hA555, 8'h6D, 2,  2, 15, 1, 6};
    tbl[5] = '{16'hAAA3, 16'hAAAC, 8'hB7, 2,  2, 15, 1, 0};

    tick(1, 0, 0, 2'b00, 2'b00);
    tick(1, 1, 1, 2'b11, 2'b00);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_checked", checked_cnt, 0);
    tick(0, 0, 1, 2'b11, 2'b00);
    check("idle_ignores_valid", busy, 0);

    for (int k = 0; k < 6; k++) begin
      tick(0, 1, 0, 2'b00, 2'b00);
      check("run_start_busy", busy, 1);
      run_vec(tbl[k].gold, tbl[k].dutv, tbl[k].vpat);
      check("tbl_type1", type1_cnt, tbl[k].t1);
      check("tbl_type2", type2_cnt, tbl[k].t2);
      check("tbl_checked", checked_cnt, tbl[k].chk);
      check("tbl_err_flag", err_flag, tbl[k].err);
      check("tbl_first_idx", first_err_idx, tbl[k].first);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 2'b11, 2'b00);
      check("tbl_done_holds", done, 1);
      check("tbl_type1_holds", type1_cnt, tbl[k].t1);
    end

    // Reset mid-run with two errors already counted.
    tick(0, 1, 0, 2'b00, 2'b00);
    for (int s = 0; s < 5; s++) tick(0, 0, 1, 2'b11, (s < 2) ? 2'b01 : 2'b00);
    tick(0, 0, 0, 2'b00, 2'b00);
    check("mid_type1_before_rst", type1_cnt, 2);
    check("mid_busy_before_rst", busy, 1);
    tick(1, 0, 1, 2'b11, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_type1", type1_cnt, 0);
    check("rst_err_flag", err_flag, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 2'b00, 2'b00);
    check("post_rst_type1", type1_cnt, 0);
    check("post_rst_checked", checked_cnt, 0);

    // Restart from DONE with type1 = 3.
    tick(0, 1, 0, 2'b00, 2'b00);
    run_vec(16'h5555, 16'h5540, 8'hFF);
    check("run1_type1", type1_cnt, 3);
    check("run1_done", done, 1);
    tick(0, 1, 0, 2'b00, 2'b00);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_type1", type1_cnt, 0);
    check("restart_checked", checked_cnt, 0);
    run_vec(16'hAAAA, 16'hAAAA, 8'hFF);
    check("run2_type1", type1_cnt, 0);
    check("run2_checked", checked_cnt, 15);
    check("run2_done", done, 1);

    // Random traffic, occasional resets and starts.
    for (int i = 0; i < 2000; i++) begin
      tick(($urandom_range(0, 249) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
